// File: rtl/gcd_sched_if.sv
// Bus bundle between requesters, the gcd_sched arbiter and the shared GCD core.
// Signal suffixes are from the scheduler's point of view.
interface gcd_sched_if #(
    parameter int GCDw = 32,
    parameter int NREQ = 4
);
    logic [NREQ-1:0]      req_i;
    logic [NREQ*GCDw-1:0] in1_i;
    logic [NREQ*GCDw-1:0] in2_i;
    logic [NREQ-1:0]      gnt_o;
    logic [NREQ-1:0]      done_o;
    logic [GCDw-1:0]      result_o;
    logic                 err_o;
    logic                 gcd_reset_o;
    logic                 gcd_enable_o;
    logic [GCDw-1:0]      gcd_in1_o;
    logic [GCDw-1:0]      gcd_in2_o;
    logic                 gcd_done_i;
    logic [GCDw-1:0]      gcd_i;

    modport slave (
        input  req_i, in1_i, in2_i, gcd_done_i, gcd_i,
        output gnt_o, done_o, result_o, err_o,
        output gcd_reset_o, gcd_enable_o, gcd_in1_o, gcd_in2_o
    );

    modport master (
        output req_i, in1_i, in2_i, gcd_done_i, gcd_i,
        input  gnt_o, done_o, result_o, err_o,
        input  gcd_reset_o, gcd_enable_o, gcd_in1_o, gcd_in2_o
    );
endinterface

// File: rtl/gcd_sched.sv
// Round-robin scheduler sharing one GCD core among NREQ requesters.
// Optional WAIT timeout enabled by defining GCD_SCHED_TIMEOUT_EN.
module gcd_sched #(
    parameter int GCDw  = 32,
    parameter int NREQ  = 4,
    parameter int TOUTw = 16
) (
    input  logic          clk,
    input  logic          reset,
    gcd_sched_if.slave    bus
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        START = 3'd2,
        WAIT  = 3'd3,
        RESP  = 3'd4
    } state_t;

    state_t          state_q;
    logic [PW-1:0]   ptr_q;
    logic [PW-1:0]   win_q;
    logic [NREQ-1:0] gnt_q;
    logic [NREQ-1:0] done_q;
    logic [GCDw-1:0] result_q;
    logic [GCDw-1:0] in1_q;
    logic [GCDw-1:0] in2_q;
    logic            gcd_reset_q;
    logic            gcd_enable_q;

    logic [PW-1:0]   win_d;
    logic [PW-1:0]   ptr_d;
    logic [NREQ-1:0] gnt_d;
    logic            found_s;
    int              idx_s;

`ifdef GCD_SCHED_TIMEOUT_EN
    localparam logic [TOUTw-1:0] TOUT_LAST = ~TOUTw'(1'b1);
    logic [TOUTw-1:0] tout_q;
    logic             err_q;
    assign bus.err_o = err_q;
`else
    logic unused_tout_s;
    assign unused_tout_s = (TOUTw > 0);
    assign bus.err_o     = 1'b0;
`endif

    // Round-robin search over requesters starting at ptr_q
    always_comb begin
        idx_s   = 0;
        win_d   = '0;
        found_s = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            idx_s = (int'(ptr_q) + i) % NREQ;
            if (!found_s && bus.req_i[idx_s]) begin
                found_s = 1'b1;
                win_d   = PW'(idx_s);
            end else begin
                found_s = found_s;
            end
        end
    end

    assign ptr_d = (win_d == PW'(NREQ - 1)) ? '0 : win_d + PW'(1'b1);
    assign gnt_d = {{(NREQ-1){1'b0}}, 1'b1} << win_d;

    // Service FSM with all outputs registered
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            win_q        <= '0;
            gnt_q        <= '0;
            done_q       <= '0;
            result_q     <= '0;
            in1_q        <= '0;
            in2_q        <= '0;
            gcd_reset_q  <= 1'b1;
            gcd_enable_q <= 1'b0;
`ifdef GCD_SCHED_TIMEOUT_EN
            tout_q       <= '0;
            err_q        <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    gcd_enable_q <= 1'b0;
                    done_q       <= '0;
                    if (|bus.req_i) begin
                        gnt_q       <= gnt_d;
                        win_q       <= win_d;
                        ptr_q       <= ptr_d;
                        gcd_reset_q <= 1'b1;
                        state_q     <= LOAD;
                    end else begin
                        gnt_q       <= '0;
                        gcd_reset_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                LOAD: begin
                    // Operands are frozen here; later input changes are ignored
                    in1_q        <= bus.in1_i[win_q*GCDw +: GCDw];
                    in2_q        <= bus.in2_i[win_q*GCDw +: GCDw];
                    gcd_reset_q  <= 1'b0;
                    gcd_enable_q <= 1'b1;
                    state_q      <= START;
                end
                START: begin
                    gcd_enable_q <= 1'b0;
`ifdef GCD_SCHED_TIMEOUT_EN
                    tout_q       <= '0;
`endif
                    state_q      <= WAIT;
                end
                WAIT: begin
                    if (bus.gcd_done_i) begin
                        result_q <= bus.gcd_i;
                        done_q   <= gnt_q;
`ifdef GCD_SCHED_TIMEOUT_EN
                        err_q    <= 1'b0;
`endif
                        state_q  <= RESP;
                    end
`ifdef GCD_SCHED_TIMEOUT_EN
                    else if (tout_q == TOUT_LAST) begin
                        result_q <= '0;
                        done_q   <= gnt_q;
                        err_q    <= 1'b1;
                        state_q  <= RESP;
                    end else begin
                        tout_q   <= tout_q + TOUTw'(1'b1);
                        state_q  <= WAIT;
                    end
`else
                    else begin
                        state_q  <= WAIT;
                    end
`endif
                end
                RESP: begin
                    done_q  <= '0;
                    gnt_q   <= '0;
                    state_q <= IDLE;
                end
                default: begin
                    done_q       <= '0;
                    gnt_q        <= '0;
                    gcd_reset_q  <= 1'b0;
                    gcd_enable_q <= 1'b0;
                    state_q      <= IDLE;
                end
            endcase
        end
    end

    assign bus.gnt_o        = gnt_q;
    assign bus.done_o       = done_q;
    assign bus.result_o     = result_q;
    assign bus.gcd_reset_o  = gcd_reset_q;
    assign bus.gcd_enable_o = gcd_enable_q;
    assign bus.gcd_in1_o    = in1_q;
    assign bus.gcd_in2_o    = in2_q;
endmodule

// File: tb/tb_gcd_sched.sv
// Directed bench for gcd_sched with a behavioural GCD core of fixed latency.
module tb_gcd_sched;
    localparam int GCDW = 32;
    localparam int NREQ = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    gcd_sched_if #(.GCDw(GCDW), .NREQ(NREQ)) bif();

    gcd_sched #(.GCDw(GCDW), .NREQ(NREQ), .TOUTw(4)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bif)
    );

    int  n_tests = 0;
    int  n_fail  = 0;

    // Behavioural GCD core
    int          core_lat  = 5;
    bit          core_hang = 1'b0;
    logic [31:0] core_res;
    logic        core_done;
    logic        core_busy;
    int          core_cnt;
    assign bif.gcd_done_i = core_done;
    assign bif.gcd_i      = core_res;

    function automatic logic [31:0] euclid(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] t;
        while (b != 32'd0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_busy <= 1'b0;
            core_cnt  <= 0;
            core_done <= 1'b0;
            core_res  <= 32'd0;
        end else begin
            core_done <= 1'b0;
            if (bif.gcd_reset_o) begin
                core_busy <= 1'b0;
            end else if (bif.gcd_enable_o) begin
                core_busy <= 1'b1;
                core_cnt  <= core_lat;
                core_res  <= euclid(bif.gcd_in1_o, bif.gcd_in2_o);
            end else if (core_busy && !core_hang) begin
                if (core_cnt <= 1) begin
                    core_done <= 1'b1;
                    core_busy <= 1'b0;
                end else begin
                    core_cnt <= core_cnt - 1;
                end
            end
        end
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic set_slot(input int k, input logic [31:0] a, input logic [31:0] b);
        bif.in1_i[k*GCDW +: GCDW] = a;
        bif.in2_i[k*GCDW +: GCDW] = b;
    endtask

    task automatic set_ops(input logic [3:0] req, input int win, input logic [31:0] a, input logic [31:0] b);
        for (int k = 0; k < NREQ; k++) begin
            set_slot(k, 32'hDEAD_0000 | 32'(k), 32'd1);
        end
        set_slot(win, a, b);
        bif.req_i = req;
    endtask

    task automatic wait_enable(input string nm);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (bif.gcd_enable_o) seen = 1'b1;
        end
        check({nm, " enable seen"}, 64'(seen), 64'd1);
    endtask

    task automatic wait_done(input logic [3:0] exp_gnt, input logic [31:0] exp_res,
                             input logic exp_err, input string nm);
        bit seen_gnt, held_ok, prev_gd, got;
        seen_gnt = 1'b0; held_ok = 1'b1; prev_gd = 1'b0; got = 1'b0;
        for (int c = 0; c < 300 && !got; c++) begin
            @(negedge clk);
            if (bif.done_o != 4'd0) begin
                got = 1'b1;
            end else begin
                if (bif.gnt_o != 4'd0) begin
                    if (!seen_gnt) begin
                        seen_gnt = 1'b1;
                        check({nm, " grant"}, 64'(bif.gnt_o), 64'(exp_gnt));
                    end else if (bif.gnt_o !== exp_gnt) begin
                        held_ok = 1'b0;
                    end
                end
                prev_gd = bif.gcd_done_i;
            end
        end
        if (!got) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s timeout: no done_o within 300 cycles", nm);
        end else begin
            check({nm, " grant seen"}, 64'(seen_gnt), 64'd1);
            check({nm, " grant held"}, 64'(held_ok), 64'd1);
            check({nm, " done_o"}, 64'(bif.done_o), 64'(exp_gnt));
            check({nm, " gnt in resp"}, 64'(bif.gnt_o), 64'(exp_gnt));
            check({nm, " result"}, 64'(bif.result_o), 64'(exp_res));
            check({nm, " err"}, 64'(bif.err_o), 64'(exp_err));
            if (!exp_err) check({nm, " done latency"}, 64'(prev_gd), 64'd1);
            @(negedge clk);
            check({nm, " done pulse"}, 64'(bif.done_o), 64'd0);
            check({nm, " gnt cleared"}, 64'(bif.gnt_o), 64'd0);
            check({nm, " result hold"}, 64'(bif.result_o), 64'(exp_res));
        end
    endtask

    typedef struct {
        logic [3:0]  req;
        int          win;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
    } vec_t;

    vec_t vecs[9];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit no_done;
        int n;
        vecs[0] = '{4'b1111, 1, 32'd21,  32'd14, 32'd7};
        vecs[1] = '{4'b1111, 2, 32'd35,  32'd49, 32'd7};
        vecs[2] = '{4'b1111, 3, 32'd100, 32'd75, 32'd25};
        vecs[3] = '{4'b1111, 0, 32'd17,  32'd5,  32'd1};
        vecs[4] = '{4'b0001, 0, 32'd48,  32'd0,  32'd48};
        vecs[5] = '{4'b1000, 3, 32'd81,  32'd27, 32'd27};
        vecs[6] = '{4'b0110, 1, 32'd1,   32'd1,  32'd1};
        vecs[7] = '{4'b0011, 0, 32'd64,  32'd48, 32'd16};
        vecs[8] = '{4'b1010, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};

        bif.req_i = 4'd0;
        bif.in1_i = '0;
        bif.in2_i = '0;
        repeat (3) @(negedge clk);
        check("rst gnt", 64'(bif.gnt_o), 64'd0);
        check("rst done", 64'(bif.done_o), 64'd0);
        check("rst result", 64'(bif.result_o), 64'd0);
        check("rst err", 64'(bif.err_o), 64'd0);
        check("rst gcd_reset", 64'(bif.gcd_reset_o), 64'd1);
        check("rst gcd_enable", 64'(bif.gcd_enable_o), 64'd0);
        check("rst gcd_in1", 64'(bif.gcd_in1_o), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post-rst gcd_reset", 64'(bif.gcd_reset_o), 64'd0);

        // Minimum-latency single request: 12,18 -> 6
        set_ops(4'b0001, 0, 32'd12, 32'd18);
        @(negedge clk);
        check("lat gnt", 64'(bif.gnt_o), 64'd1);
        check("lat gcd_reset c1", 64'(bif.gcd_reset_o), 64'd1);
        check("lat gcd_enable c1", 64'(bif.gcd_enable_o), 64'd0);
        @(negedge clk);
        check("lat gcd_reset c2", 64'(bif.gcd_reset_o), 64'd0);
        check("lat gcd_enable c2", 64'(bif.gcd_enable_o), 64'd1);
        check("lat gcd_in1", 64'(bif.gcd_in1_o), 64'd12);
        check("lat gcd_in2", 64'(bif.gcd_in2_o), 64'd18);
        @(negedge clk);
        check("lat gcd_enable c3", 64'(bif.gcd_enable_o), 64'd0);
        wait_done(4'b0001, 32'd6, 1'b0, "single");

        for (int i = 0; i < 9; i++) begin
            set_ops(vecs[i].req, vecs[i].win, vecs[i].a, vecs[i].b);
            wait_done(4'b0001 << vecs[i].win, vecs[i].res, 1'b0, $sformatf("vec%0d", i));
        end

        // Operand change during WAIT must not disturb the running job
        set_ops(4'b0100, 2, 32'd35, 32'd49);
        wait_enable("opchg");
        repeat (2) @(negedge clk);
        set_slot(2, 32'd99, 32'd49);
        wait_done(4'b0100, 32'd7, 1'b0, "opchg");

        // Requester 3 drops req during START; requester 0 served next
        bif.req_i = 4'b1001;
        set_slot(3, 32'd100, 32'd75);
        set_slot(0, 32'd42, 32'd56);
        wait_enable("drop");
        bif.req_i = 4'b0001;
        wait_done(4'b1000, 32'd25, 1'b0, "drop r3");
        wait_done(4'b0001, 32'd14, 1'b0, "drop next r0");
        bif.req_i = 4'd0;

        // Reset asserted in WAIT abandons the job
        set_ops(4'b0010, 1, 32'd9, 32'd6);
        wait_enable("midrst");
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        bif.req_i = 4'd0;
        #1;
        check("midrst gnt", 64'(bif.gnt_o), 64'd0);
        check("midrst done", 64'(bif.done_o), 64'd0);
        check("midrst gcd_reset", 64'(bif.gcd_reset_o), 64'd1);
        check("midrst gcd_enable", 64'(bif.gcd_enable_o), 64'd0);
        check("midrst result", 64'(bif.result_o), 64'd0);
        no_done = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (bif.done_o != 4'd0) no_done = 1'b0;
        end
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst no done", 64'(no_done), 64'd1);
        check("midrst release gcd_reset", 64'(bif.gcd_reset_o), 64'd0);
        set_ops(4'b0100, 2, 32'd9, 32'd6);
        wait_done(4'b0100, 32'd3, 1'b0, "after rst");
        bif.req_i = 4'd0;

`ifdef GCD_SCHED_TIMEOUT_EN
        // Hung core: RESP after 15 WAIT cycles with err set
        core_hang = 1'b1;
        set_ops(4'b0001, 0, 32'd12, 32'd18);
        wait_enable("tout");
        n = 0;
        while (n < 100 && bif.done_o == 4'd0) begin
            @(negedge clk);
            n++;
        end
        check("tout cycles", 64'(n), 64'd16);
        check("tout done", 64'(bif.done_o), 64'd1);
        check("tout err", 64'(bif.err_o), 64'd1);
        check("tout result", 64'(bif.result_o), 64'd0);
        bif.req_i = 4'd0;
        core_hang = 1'b0;
        @(negedge clk);
`else
        n = 0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
